// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// lane widths and the alignment rules used at request accept.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WRITE  = 2'b10,
        RESP   = 2'b11
    } lsu_state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    // The reserved encoding 2'b11 behaves as a word access.
    function automatic size_e norm_size(input logic [1:0] s);
        return (s == 2'b11) ? SIZE_WORD : size_e'(s);
    endfunction

    function automatic logic misaligned(input size_e s, input logic [1:0] off);
        case (s)
            SIZE_HALF: return off[0];
            SIZE_WORD: return (off != 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

    // Low address bits that must be zero for an aligned access of size s.
    function automatic logic [1:0] align_mask(input size_e s);
        case (s)
            SIZE_HALF: return 2'b01;
            SIZE_WORD: return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: little-endian load extract/extend and
// sub-word store merge into the word read back from memory.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] ld_word,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              sign_ext,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] ld_data,
    output logic [WORD_W-1:0] st_word
);

    logic [4:0]        byte_lsb;
    logic [4:0]        half_lsb;
    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    assign byte_lsb = {offset, 3'b000};
    assign half_lsb = {offset[1], 4'b0000};
    assign byte_v   = ld_word[byte_lsb +: BYTE_W];
    assign half_v   = ld_word[half_lsb +: HALF_W];

    always_comb begin
        ld_data = ld_word;
        st_word = wdata;
        case (size)
            SIZE_BYTE: begin
                ld_data = {{(WORD_W-BYTE_W){sign_ext & byte_v[BYTE_W-1]}}, byte_v};
                st_word = old_word;
                st_word[byte_lsb +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SIZE_HALF: begin
                ld_data = {{(WORD_W-HALF_W){sign_ext & half_v[HALF_W-1]}}, half_v};
                st_word = old_word;
                st_word[half_lsb +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: begin
                ld_data = ld_word;
                st_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU data-memory initiator: byte/half/word loads and stores over a word-wide
// port, sub-word stores by read-modify-write. Define LSU_MISALIGN_TRAP_EN to
// fault misaligned requests instead of silently aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_writeEn,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_writeData,
    input  logic [31:0]       mem_readData,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready;
    // req_ready is high only in IDLE, resp_valid is a single-cycle pulse in RESP.

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_WRITE  = WRITE;
    localparam logic [1:0] ST_RESP   = RESP;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [1:0]        state;
    logic              lat_write;
    size_e             lat_size;
    logic              lat_signed;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       merged;
    logic              fault_q;

    size_e             acc_size;
    logic              acc_mis;
    logic [ADDR_W-1:0] acc_addr;
    logic              word_store;
    logic [31:0]       ld_data;
    logic [31:0]       st_word;

    assign acc_size = norm_size(req_size);
    assign acc_mis  = misaligned(acc_size, req_addr[1:0]);
    // Without the trap, misaligned requests drop their low offset bits here.
    assign acc_addr = {req_addr[ADDR_W-1:2], req_addr[1:0] & ~align_mask(acc_size)};

    assign word_store = lat_write && (lat_size == SIZE_WORD);

    lsu_lane_align u_align (
        .ld_word  (mem_readData),
        .offset   (lat_addr[1:0]),
        .size     (lat_size),
        .sign_ext (lat_signed),
        .old_word (mem_readData),
        .wdata    (lat_wdata),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lat_write  <= 1'b0;
            lat_size   <= SIZE_BYTE;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            merged     <= '0;
            resp_rdata <= '0;
            fault_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= acc_size;
                        lat_signed <= req_signed;
                        lat_addr   <= acc_addr;
                        lat_wdata  <= req_wdata;
                        if (TRAP_EN && acc_mis) begin
                            resp_rdata <= '0;
                            fault_q    <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!lat_write) begin
                        resp_rdata <= ld_data;
                        fault_q    <= 1'b0;
                        state      <= ST_RESP;
                    end else if (word_store) begin
                        resp_rdata <= '0;
                        fault_q    <= 1'b0;
                        state      <= ST_RESP;
                    end else begin
                        merged <= st_word;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    resp_rdata <= '0;
                    fault_q    <= 1'b0;
                    state      <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write enable and data are decoded from state so reset removes them at once.
    always_comb begin
        mem_writeEn   = 1'b0;
        mem_writeData = '0;
        if (state == ST_WRITE) begin
            mem_writeEn   = 1'b1;
            mem_writeData = merged;
        end else if (state == ST_ACCESS && word_store) begin
            mem_writeEn   = 1'b1;
            mem_writeData = lat_wdata;
        end
    end

    assign mem_address = 32'(lat_addr[ADDR_W-1:2]);
    assign req_ready   = (state == ST_IDLE);
    assign resp_valid  = (state == ST_RESP);
    assign resp_fault  = fault_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed steps plus random traffic checked against
// an arithmetic model of a 16-word memory.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_writeEn;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;
    logic [1:0]  dbg_state;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] last_rdata;
    logic        last_fault;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .mem_writeEn   (mem_writeEn),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory: combinational read, write on the rising edge
    assign mem_readData = mem[mem_address[3:0]];
    always @(posedge clk) begin
        if (mem_writeEn) begin
            mem[mem_address[3:0]] <= mem_writeData;
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_address;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: applies one request to ref_mem and returns its expected response
    function automatic void model(input logic w, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rdata, output logic fault,
                                  output int lat, output int wes);
        int          nbytes;
        int          wi;
        int          sh;
        logic [31:0] mask;
        logic [31:0] val;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        rdata  = '0;
        fault  = 1'b0;
        wes    = 0;
        lat    = 2;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((a % nbytes) != 0) begin
            fault = 1'b1;
            lat   = 1;
            return;
        end
`else
        a = a - (a % nbytes);
`endif
        wi   = (a / 4) % 16;
        sh   = 8 * (a % 4);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        if (!w) begin
            val = (ref_mem[wi] >> sh) & mask;
            if (sg && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
            rdata = val;
        end else begin
            ref_mem[wi] = (ref_mem[wi] & ~(mask << sh)) | ((wd & mask) << sh);
            lat = (nbytes == 4) ? 2 : 3;
            wes = 1;
        end
    endfunction

    // driver: issue one request at a falling edge and check its full response
    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] e_rd;
        logic        e_f;
        int          e_lat;
        int          e_we;
        int          lat;
        int          we0;
        int          wi;
        model(w, sz, sg, a, wd, e_rd, e_f, e_lat, e_we);
        wi = int'(a[5:2]);
        check32({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check32({tag, "/lat"}, 32'(lat), 32'(e_lat));
        check32({tag, "/rdata"}, resp_rdata, e_rd);
        check32({tag, "/fault"}, 32'(resp_fault), 32'(e_f));
        last_rdata = resp_rdata;
        last_fault = resp_fault;
        @(negedge clk);
        check32({tag, "/we_cnt"}, 32'(we_cnt - we0), 32'(e_we));
        if (e_we != 0) check32({tag, "/we_addr"}, we_addr, 32'(wi));
        check32({tag, "/mem"}, mem[wi], ref_mem[wi]);
    endtask

    initial begin
        logic [31:0] e_rd;
        logic        e_f;
        int          e_lat;
        int          e_we;
        int          we0;
        int          accepts;
        int          resps;
        int          t;
        logic [31:0] a;
        logic        sg;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        check32("rst/ready", 32'(req_ready), 32'd1);
        check32("rst/resp_valid", 32'(resp_valid), 32'd0);
        check32("rst/rdata", resp_rdata, 32'd0);
        check32("rst/fault", 32'(resp_fault), 32'd0);
        check32("rst/we", 32'(mem_writeEn), 32'd0);
        check32("rst/addr", mem_address, 32'd0);
        check32("rst/wdata", mem_writeData, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'hX;
            do_req("fill", 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);
        end

        do_req("wst10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req("wld10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check32("wld10/const", last_rdata, 32'hDEAD_BEEF);

        do_req("pre4", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        do_req("bst11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
        check32("bst11/const", mem[4], 32'h1122_AA44);

        do_req("pre4b", 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01);
        do_req("lbs12", 1'b0, 2'd0, 1'b1, 32'h12, 32'h0);
        check32("lbs12/const", last_rdata, 32'hFFFF_FFFF);
        do_req("lbu13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check32("lbu13/const", last_rdata, 32'h0000_0080);
        do_req("lhs10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        check32("lhs10/const", last_rdata, 32'h0000_7F01);
        do_req("lh11", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check32("lh11/fault_const", 32'(last_fault), 32'd1);
`else
        check32("lh11/align_const", last_rdata, 32'h0000_7F01);
`endif

        do_req("b2b0", 1'b1, 2'd0, 1'b0, 32'h18, $urandom);
        do_req("b2b1", 1'b1, 2'd0, 1'b0, 32'h19, $urandom);
        do_req("b2b2", 1'b1, 2'd1, 1'b0, 32'h1A, $urandom);

        // reset while a byte store sits in WRITE
        do_req("pre5", 1'b1, 2'd2, 1'b0, 32'h14, 32'h5566_7788);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h15;
        req_wdata = 32'h0000_00CC;
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check32("rstw/we_before", 32'(mem_writeEn), 32'd1);
        rst = 1'b0;
        #1;
        check32("rstw/we_drop", 32'(mem_writeEn), 32'd0);
        check32("rstw/ready_in_rst", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check32("rstw/mem", mem[5], 32'h5566_7788);
        check32("rstw/we_cnt", 32'(we_cnt - we0), 32'd0);
        check32("rstw/ready", 32'(req_ready), 32'd1);

        // req_valid held high: one accept per pass through IDLE
        accepts = 0;
        resps   = 0;
        for (int c = 0; c < 12; c++) begin
            if (resp_valid) begin
                resps++;
                check32("held/rdata", resp_rdata, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX);
            end
            a  = $urandom_range(0, 63);
            sg = 1'($urandom_range(0, 1));
            req_valid  = 1'b1;
            req_write  = 1'b0;
            req_size   = 2'd0;
            req_signed = sg;
            req_addr   = a;
            if (req_ready) begin
                model(1'b0, 2'd0, sg, a, 32'h0, e_rd, e_f, e_lat, e_we);
                exp_q.push_back(e_rd);
                accepts++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        t = 0;
        while (exp_q.size() > 0 && t < 8) begin
            if (resp_valid) begin
                resps++;
                check32("held/rdata", resp_rdata, exp_q.pop_front());
            end
            @(negedge clk);
            t++;
        end
        check32("held/accepts", 32'(accepts), 32'd4);
        check32("held/resps", 32'(resps), 32'd4);
        check32("held/drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the CPU data-memory interface. It accepts byte, halfword and word load/store requests from the execute stage and drives the word-wide `DataMemory` port (`writeEn`/`address`/`writeData`/`readData`). Sub-word stores are done as a read-modify-write, because the memory has only whole-word write enables. Loads are returned lane-aligned and zero- or sign-extended.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width of CPU requests.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: reset. Asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request; high only in IDLE.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: access size, `size_e` (byte / half / word).
- `req_signed`  in  1: sign-extend load data; ignored for stores.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, right-justified.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_rdata`  out  32: extended load data; 0 for stores.
- `resp_fault`  out  1: misaligned access aborted; valid with `resp_valid`.
- `mem_writeEn`  out  1: to memory `writeEn`.
- `mem_address`  out  32: word index, `{2'b00, addr[ADDR_W-1:2]}`.
- `mem_writeData`  out  32: to memory `writeData`.
- `mem_readData`  in  32: from memory `readData`; combinational, valid in the same cycle as `mem_address`.

## Operation
- Endianness is little-endian. Byte lane n = `addr[1:0]` occupies bits [8n+7:8n]. Half lane h = `addr[1]` occupies bits [16h+15:16h].
- A request is accepted on the rising edge where `req_valid && req_ready`. All request fields are latched at that edge.
- States:
  - IDLE: `req_ready`=1. On accept: go to RESP if the access is misaligned and faulting, otherwise go to ACCESS.
  - ACCESS: `mem_address` is driven from the latched address.
    - Load: extract the lane, extend it, register it into `resp_rdata`, go to RESP.
    - Word store: `mem_writeEn`=1, `mem_writeData`=wdata, go to RESP.
    - Byte/half store: register the merged word, go to WRITE. The merged word is `mem_readData` with the target lane replaced by the low bits of wdata.
  - WRITE: `mem_writeEn`=1, `mem_writeData`=merged word, go to RESP.
  - RESP: `resp_valid`=1, go to IDLE.
- Misaligned means: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Sign or zero extension applies to byte and half loads only.
- `mem_writeEn` is high only in ACCESS (word store) and in WRITE.
- Reserved size value 2'b11 is treated as word.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `mem_writeEn`=0, `mem_address`=0, `mem_writeData`=0.
- `resp_valid` rises N cycles after the accept edge:
  - 2 cycles for loads and word stores.
  - 3 cycles for sub-word stores.
  - 1 cycle for a fault.
- Throughput: one request per 3 or 4 cycles. A new request is accepted no earlier than the edge that leaves RESP.
- `req_valid` during a busy state is ignored; `req_ready`=0.
- `resp_rdata` and `resp_fault` hold their values until the next response.
- Reset asserted mid-operation: the unit returns to IDLE immediately and `mem_writeEn` drops at once. A pending WRITE is dropped, leaving memory untouched.
- Back-to-back stores to the same word see the prior write, because the read happens after the previous RESP.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned request goes IDLE→RESP with `resp_fault`=1 and `resp_rdata`=0.
  - No memory cycle occurs.
- Not defined:
  - `resp_fault` is tied to 0.
  - Misaligned addresses are forced aligned by clearing the low bits (`addr[0]` for half, `addr[1:0]` for word), and the access proceeds normally.

## Structure
- Package `lsu_pkg` holds:
  - `typedef enum logic [1:0] size_e {SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10}`.
  - `lsu_state_e` {IDLE, ACCESS, WRITE, RESP}.
  - Lane width constants.
- Sub-module `lsu_lane_align` (combinational):
  - Load extract/extend: inputs word, offset, size, signed.
  - Store merge: inputs old word, wdata, offset, size.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10 → `mem_address`=4 with `mem_writeEn` high one cycle; load returns 0xDEADBEEF 2 cycles after accept.
- Memory word 4 = 0x11223344; byte store 0xAA to 0x11 → one read cycle, then write 0x1122AA44; `resp_valid` 3 cycles after accept.
- Memory word 4 = 0x80FF7F01:
  - signed byte load 0x12 → 0xFFFFFFFF;
  - unsigned byte load 0x13 → 0x00000080;
  - signed half load 0x10 → 0x00007F01.
- Half load at 0x11:
  - macro defined → `resp_fault`=1 one cycle after accept, `mem_writeEn` never high;
  - macro undefined → reads half at 0x10.
- Reset asserted during WRITE of a byte store → `mem_writeEn` drops immediately; memory word is unchanged; `req_ready`=1 after reset release.
- `req_valid` held high continuously → exactly one accept per RESP→IDLE cycle; busy-state requests are not latched.
